// File: rtl/servant_gpio_in_if.sv
// Wishbone bus bundle between the servant SoC interconnect and the debounced
// GPIO input responder. Signal names follow the responder's view of the bus.
interface servant_gpio_in_if;
  logic [1:0]  i_wb_adr;
  logic [31:0] i_wb_dat;
  logic [3:0]  i_wb_sel;
  logic        i_wb_we;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;

  modport master (
    output i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb,
    input  o_wb_rdt, o_wb_ack
  );

  modport slave (
    input  i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb,
    output o_wb_rdt, o_wb_ack
  );
endinterface

// File: rtl/servant_gpio_in.sv
// Debounced general-purpose input port for the servant SoC. Each pin is
// synchronised and debounced; stable-level edges are latched into sticky
// write-1-to-clear pend registers, and enabled pend bits raise a level irq.
// Registers: 0x0 DATA (ro), 0x4 RISE_PEND (w1c), 0x8 FALL_PEND (w1c),
// 0xC IRQ_EN (rise enables in [15:0], fall enables in [31:16]).
module servant_gpio_in #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              wb_clk,
  input  logic              wb_rstn,
  servant_gpio_in_if.slave  wb,
  input  logic [WIDTH-1:0]  i_gpio,
  output logic              o_irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] rise_pend_q, rise_pend_d;
  logic [WIDTH-1:0] fall_pend_q, fall_pend_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic             ack_q, ack_d;
  logic [31:0]      rdt_q, rdt_d;
  logic             irq_q, irq_d;

  logic             xfer;
  logic             wr;
  logic [31:0]      bmask;
  logic [31:0]      wdat;
  logic [WIDTH-1:0] rise_set, fall_set;
  logic [WIDTH-1:0] rise_clr, fall_clr;
  logic [31:0]      rd_word;
  logic             unused_wdat;

  // Bits of the masked write word beyond the implemented pins are dropped.
  assign unused_wdat = ^wdat;

  // Synchroniser chain and per-pin debounce counter.
  always_comb begin
    sync1_d  = i_gpio;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Bus decode, pend set/clear (set wins), enable writes, read mux, irq.
  always_comb begin
    xfer  = wb.i_wb_cyc & wb.i_wb_stb & ~ack_q;
    wr    = xfer & wb.i_wb_we;
    bmask = {{8{wb.i_wb_sel[3]}}, {8{wb.i_wb_sel[2]}},
             {8{wb.i_wb_sel[1]}}, {8{wb.i_wb_sel[0]}}};
    wdat  = wb.i_wb_dat & bmask;

    rise_set = stable_d & ~stable_q;
    fall_set = ~stable_d & stable_q;
    rise_clr = (wr && wb.i_wb_adr == 2'd1) ? wdat[WIDTH-1:0] : '0;
    fall_clr = (wr && wb.i_wb_adr == 2'd2) ? wdat[WIDTH-1:0] : '0;
    rise_pend_d = (rise_pend_q & ~rise_clr) | rise_set;
    fall_pend_d = (fall_pend_q & ~fall_clr) | fall_set;

    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    if (wr && wb.i_wb_adr == 2'd3) begin
      rise_en_d = (rise_en_q & ~bmask[WIDTH-1:0]) | wdat[WIDTH-1:0];
      fall_en_d = (fall_en_q & ~bmask[16 +: WIDTH]) | wdat[16 +: WIDTH];
    end

    rd_word = '0;
    case (wb.i_wb_adr)
      2'd0: rd_word[WIDTH-1:0] = stable_q;
      2'd1: rd_word[WIDTH-1:0] = rise_pend_q;
      2'd2: rd_word[WIDTH-1:0] = fall_pend_q;
      default: begin
        rd_word[WIDTH-1:0]  = rise_en_q;
        rd_word[16 +: WIDTH] = fall_en_q;
      end
    endcase

    rdt_d = (xfer && !wb.i_wb_we) ? rd_word : rdt_q;
    ack_d = xfer;
    irq_d = (|(rise_pend_q & rise_en_q)) | (|(fall_pend_q & fall_en_q));
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge wb_clk) begin
    if (!wb_rstn) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      rise_pend_q <= '0;
      fall_pend_q <= '0;
      rise_en_q   <= '0;
      fall_en_q   <= '0;
      ack_q       <= 1'b0;
      rdt_q       <= '0;
      irq_q       <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      stable_q    <= stable_d;
      cnt_q       <= cnt_d;
      rise_pend_q <= rise_pend_d;
      fall_pend_q <= fall_pend_d;
      rise_en_q   <= rise_en_d;
      fall_en_q   <= fall_en_d;
      ack_q       <= ack_d;
      rdt_q       <= rdt_d;
      irq_q       <= irq_d;
    end
  end

  assign wb.o_wb_ack = ack_q;
  assign wb.o_wb_rdt = rdt_q;
  assign o_irq       = irq_q;

endmodule
